// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: ALU_16 opcode encodings, requester ids and the response
// record shared by the arbiter, its grant sub-module and the ALU.
// The ALU_* macros are only defined here if nothing else has defined them.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_SLL 3'd5
`define ALU_SRL 3'd6
`define ALU_SRA 3'd7
`endif

package alu_arbiter_pkg;
    localparam logic REQ0  = 1'b0;
    localparam logic REQ1  = 1'b1;
    localparam int   ALU_W = 16;

    // Everything loaded into the response slot on an accepting edge.
    typedef struct packed {
        logic             id;
        logic [ALU_W-1:0] out;
        logic             z;
        logic             v;
        logic             n;
    } rsp_t;
endpackage

// File: rtl/ALU_16.sv
// ALU_16: 16-bit combinational ALU. z reflects a zero result for every op;
// n and v are only produced by ADD/SUB and are 0 for logic and shift ops.
// Shift amounts of 16 or more flush the operand (sign fill for SRA).
module ALU_16 (
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] out,
    output logic        z,
    output logic        v,
    output logic        n
);
    logic [3:0]  shamt;
    logic        big;
    logic [15:0] sum;
    logic [15:0] dif;
    logic        arith;

    assign shamt = b[3:0];
    assign big   = |b[15:4];
    assign sum   = a + b;
    assign dif   = a - b;

    // Result mux and overflow per opcode.
    always_comb begin
        out   = '0;
        v     = 1'b0;
        arith = 1'b0;
        case (op)
            `ALU_ADD: begin
                out   = sum;
                v     = (a[15] == b[15]) && (sum[15] != a[15]);
                arith = 1'b1;
            end
            `ALU_SUB: begin
                out   = dif;
                v     = (a[15] != b[15]) && (dif[15] != a[15]);
                arith = 1'b1;
            end
            `ALU_AND: out = a & b;
            `ALU_OR:  out = a | b;
            `ALU_XOR: out = a ^ b;
            `ALU_SLL: out = big ? 16'h0000 : (a << shamt);
            `ALU_SRL: out = big ? 16'h0000 : (a >> shamt);
            `ALU_SRA: out = big ? {16{a[15]}} : 16'($signed(a) >>> shamt);
            default:  out = '0;
        endcase
    end

    assign z = (out == 16'h0000);
    assign n = arith & out[15];
endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way one-hot grant. Default build is round-robin with a
// pointer that flips to the loser after every accept; defining
// ALU_ARB_FIXED_PRIO_EN gives requester 0 fixed priority and drops the pointer.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_arb;
    assign unused_arb = clk ^ rst ^ advance;

    // Requester 0 always wins a tie.
    always_comb begin
        gnt = 2'b00;
        if (req[0])      gnt = 2'b01;
        else if (req[1]) gnt = 2'b10;
    end
`else
    logic ptr;

    // Pointer moves to the other requester after each accept, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst)          ptr <= REQ0;
        else if (advance) ptr <= gnt[1] ? REQ0 : REQ1;
    end

    // Single requester wins outright; a tie goes to the pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == REQ0) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU_16 between two valid/ready requesters and
// returns registered result/flags tagged with the requester id through a
// single-entry response slot that can drain and refill in the same cycle.
// Optional macro: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [OPW-1:0]   r0_op,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [OPW-1:0]   r1_op,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_z,
    output logic             rsp_v,
    output logic             rsp_n
);
    // The ALU is a fixed 16-bit, 3-bit-opcode unit.
    generate
        if (WIDTH != 16 || OPW != 3) begin : g_bad_width
            $error("alu_arbiter: WIDTH must be 16 and OPW must be 3");
        end
    endgenerate

    logic             can_accept;
    logic [1:0]       gnt;
    logic             accept;
    logic             win_id;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_out;
    logic             alu_z;
    logic             alu_v;
    logic             alu_n;
    logic             slot_full;
    rsp_t             slot_q;

    assign can_accept = !slot_full | rsp_ready;
    assign accept     = can_accept & (|gnt);
    assign r0_ready   = can_accept & gnt[0];
    assign r1_ready   = can_accept & gnt[1];
    assign win_id     = gnt[1] ? REQ1 : REQ0;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({r1_valid, r0_valid}),
        .advance (accept),
        .gnt     (gnt)
    );

    // Operand mux follows the grant regardless of slot state.
    always_comb begin
        alu_op = r0_op;
        alu_a  = r0_a;
        alu_b  = r0_b;
        if (win_id == REQ1) begin
            alu_op = r1_op;
            alu_a  = r1_a;
            alu_b  = r1_b;
        end
    end

    ALU_16 u_alu (
        .op  (alu_op),
        .a   (alu_a),
        .b   (alu_b),
        .out (alu_out),
        .z   (alu_z),
        .v   (alu_v),
        .n   (alu_n)
    );

    // Response slot: load on accept, empty on a drain with no accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_full <= 1'b0;
            slot_q    <= '0;
        end else if (accept) begin
            slot_full <= 1'b1;
            slot_q    <= '{id: win_id, out: alu_out, z: alu_z, v: alu_v, n: alu_n};
        end else if (rsp_ready) begin
            slot_full <= 1'b0;
        end
    end

    assign rsp_valid = slot_full;
    assign rsp_id    = slot_q.id;
    assign rsp_out   = slot_q.out;
    assign rsp_z     = slot_q.z;
    assign rsp_v     = slot_q.v;
    assign rsp_n     = slot_q.n;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of reset, contention, single request,
// backpressure, back-to-back throughput and mid-transfer reset.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [2:0]  r0_op, r1_op;
    logic [15:0] r0_a, r0_b, r1_a, r1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_z, rsp_v, rsp_n;
    logic [15:0] rsp_out;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_z(rsp_z), .rsp_v(rsp_v), .rsp_n(rsp_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Back-to-back vectors: op, a, b, expected out, expected n
    logic [2:0]  bb_op  [8];
    logic [15:0] bb_a   [8];
    logic [15:0] bb_b   [8];
    logic [15:0] bb_out [8];
    logic        bb_n   [8];

    initial begin
        bb_op[0] = `ALU_SRL; bb_a[0] = 16'hFFFF; bb_b[0] = 16'h0000; bb_out[0] = 16'hFFFF; bb_n[0] = 1'b0;
        bb_op[1] = `ALU_ADD; bb_a[1] = 16'h0001; bb_b[1] = 16'h0001; bb_out[1] = 16'h0002; bb_n[1] = 1'b0;
        bb_op[2] = `ALU_SUB; bb_a[2] = 16'h0003; bb_b[2] = 16'h0005; bb_out[2] = 16'hFFFE; bb_n[2] = 1'b1;
        bb_op[3] = `ALU_AND; bb_a[3] = 16'hFFFF; bb_b[3] = 16'h0000; bb_out[3] = 16'h0000; bb_n[3] = 1'b0;
        bb_op[4] = `ALU_OR;  bb_a[4] = 16'h1200; bb_b[4] = 16'h0034; bb_out[4] = 16'h1234; bb_n[4] = 1'b0;
        bb_op[5] = `ALU_XOR; bb_a[5] = 16'hFFFF; bb_b[5] = 16'h0F0F; bb_out[5] = 16'hF0F0; bb_n[5] = 1'b0;
        bb_op[6] = `ALU_SLL; bb_a[6] = 16'h0001; bb_b[6] = 16'h000F; bb_out[6] = 16'h8000; bb_n[6] = 1'b0;
        bb_op[7] = `ALU_SRA; bb_a[7] = 16'h8000; bb_b[7] = 16'h0004; bb_out[7] = 16'hF800; bb_n[7] = 1'b0;

        rst = 1'b1; rsp_ready = 1'b0;
        r0_valid = 1'b0; r0_op = '0; r0_a = '0; r0_b = '0;
        r1_valid = 1'b0; r1_op = '0; r1_a = '0; r1_b = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id",    rsp_id,    0);
        chk("rst_out",   rsp_out,   0);
        chk("rst_z",     rsp_z,     0);
        chk("rst_v",     rsp_v,     0);
        chk("rst_n",     rsp_n,     0);

        // Contention: r0 ADD 0x7FFF+1 -> 0x8000 v=1 n=1; r1 SUB 0-1 -> 0xFFFF v=0 n=1
        rsp_ready = 1'b1;
        r0_valid = 1'b1; r0_op = `ALU_ADD; r0_a = 16'h7FFF; r0_b = 16'h0001;
        r1_valid = 1'b1; r1_op = `ALU_SUB; r1_a = 16'h0000; r1_b = 16'h0001;
        for (int k = 0; k < 4; k++) begin
            logic g;
`ifdef ALU_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = k[0];
`endif
            #1;
            chk("cont_r0_ready", r0_ready, !g);
            chk("cont_r1_ready", r1_ready, g);
            tick();
            chk("cont_valid", rsp_valid, 1);
            chk("cont_id",    rsp_id,    g);
            chk("cont_out",   rsp_out,   g ? 16'hFFFF : 16'h8000);
            chk("cont_v",     rsp_v,     !g);
            chk("cont_n",     rsp_n,     1);
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        tick();
        chk("drain_valid", rsp_valid, 0);
        chk("drain_hold_out", rsp_out, 16'hFFFF);

        // Single request: SRL 0xAA00 by 4
        r0_valid = 1'b1; r0_op = `ALU_SRL; r0_a = 16'hAA00; r0_b = 16'h0004;
        #1;
        chk("single_r0_ready", r0_ready, 1);
        chk("single_r1_ready", r1_ready, 0);
        tick();
        r0_valid = 1'b0;
        chk("single_valid", rsp_valid, 1);
        chk("single_id",    rsp_id,    0);
        chk("single_out",   rsp_out,   16'h0AA0);
        chk("single_z",     rsp_z,     0);
        chk("single_n",     rsp_n,     0);
        chk("single_v",     rsp_v,     0);
        tick();

        // Backpressure: SRL 0x00FF by 8 -> 0 z=1, then held with r1 queued
        rsp_ready = 1'b0;
        r0_valid = 1'b1; r0_op = `ALU_SRL; r0_a = 16'h00FF; r0_b = 16'h0008;
        #1;
        chk("bp_first_ready", r0_ready, 1);
        tick();
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_op = `ALU_AND; r1_a = 16'hF0F0; r1_b = 16'hFF00;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_r0_ready", r0_ready, 0);
            chk("bp_r1_ready", r1_ready, 0);
            chk("bp_valid",    rsp_valid, 1);
            chk("bp_out",      rsp_out, 16'h0000);
            chk("bp_z",        rsp_z, 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_r1_ready", r1_ready, 1);
        tick();
        r1_valid = 1'b0;
        chk("bp_release_valid", rsp_valid, 1);
        chk("bp_release_id",    rsp_id,    1);
        chk("bp_release_out",   rsp_out,   16'hF000);
        chk("bp_release_z",     rsp_z,     0);

        // Back-to-back: 8 accepts, rsp_ready held high
        for (int k = 0; k < 8; k++) begin
            r0_valid = 1'b1; r0_op = bb_op[k]; r0_a = bb_a[k]; r0_b = bb_b[k];
            #1;
            chk("b2b_ready", r0_ready, 1);
            tick();
            chk("b2b_valid", rsp_valid, 1);
            chk("b2b_id",    rsp_id,    0);
            chk("b2b_out",   rsp_out,   bb_out[k]);
            chk("b2b_n",     rsp_n,     bb_n[k]);
        end
        r0_valid = 1'b0;

        // Reset while FULL and stalled
        rsp_ready = 1'b0;
        tick();
        chk("pre_rst_full", rsp_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", rsp_valid, 0);
        chk("mid_rst_id",    rsp_id,    0);
        chk("mid_rst_out",   rsp_out,   0);
        chk("mid_rst_z",     rsp_z,     0);
        chk("mid_rst_v",     rsp_v,     0);
        chk("mid_rst_n",     rsp_n,     0);
        r0_valid = 1'b1; r0_op = `ALU_ADD; r0_a = 16'h0002; r0_b = 16'h0003;
        r1_valid = 1'b1; r1_op = `ALU_ADD; r1_a = 16'h0010; r1_b = 16'h0010;
        #1;
        chk("post_rst_r0_ready", r0_ready, 1);
        chk("post_rst_r1_ready", r1_ready, 0);
        tick();
        r0_valid = 1'b0; r1_valid = 1'b0;
        chk("post_rst_id",  rsp_id,  0);
        chk("post_rst_out", rsp_out, 16'h0005);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
